// File: rtl/booth_seq.sv
// Sequential radix-2 Booth multiplier: 8x8 signed operands, 16-bit signed product.
// One Booth step per clock. Done pulses 9 cycles after start is accepted.
module booth_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        busy,
   output logic        done,
   output logic [15:0] prod
);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e      state_q, state_d;
   logic [8:0]  acc_q, acc_d;
   logic [8:0]  m_q, m_d;
   logic [7:0]  q_q, q_d;
   logic        q1_q, q1_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] prod_q, prod_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Add/subtract on ACC, then arithmetic shift of {ACC, Q, q_1}.
   // ACC is 9 bits wide so that -M does not overflow when a = -128.
   logic [8:0]  sum;
   logic [8:0]  acc_sh;
   logic [7:0]  q_sh;
   logic        q1_sh;

   // One Booth step from the current register contents
   always_comb begin
      sum = acc_q;
      case ({q_q[0], q1_q})
         2'b01:   sum = acc_q + m_q;
         2'b10:   sum = acc_q - m_q;
         default: sum = acc_q;
      endcase
      acc_sh = {sum[8], sum[8:1]};
      q_sh   = {sum[0], q_q[7:1]};
      q1_sh  = q_q[0];
   end

   // Next-state and datapath updates; everything holds unless a state acts on it
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      m_d     = m_q;
      q_d     = q_q;
      q1_d    = q1_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               m_d     = {a[7], a};
               q_d     = b;
               acc_d   = 9'd0;
               q1_d    = 1'b0;
               cnt_d   = 3'd0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            acc_d = acc_sh;
            q_d   = q_sh;
            q1_d  = q1_sh;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               // Post-shift {ACC, Q} low 16 bits hold the full signed product
               prod_d  = {acc_sh[7:0], q_sh};
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // Status flags registered from the next state: no input-to-output paths
      busy_d = (state_d == StCalc);
      done_d = (state_d == StDone);
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         acc_q   <= 9'd0;
         m_q     <= 9'd0;
         q_q     <= 8'd0;
         q1_q    <= 1'b0;
         cnt_q   <= 3'd0;
         prod_q  <= 16'h0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         m_q     <= m_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign prod = prod_q;

endmodule

// File: doc/booth_seq.md
BOOTH_SEQ -- requirements
Module: booth_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 The block SHALL have these ports, one per line:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new multiply; sampled only in IDLE
- a  input  8  signed two's-complement multiplicand; captured when start is accepted
- b  input  8  signed two's-complement multiplier; captured when start is accepted
- busy  output  1  high while an operation is in progress (CALC state)
- done  output  1  one-cycle pulse; prod is valid in this cycle
- prod  output  16  signed product a*b
REQ-003 The block SHALL have no parameters; operand width is fixed at 8 and product width at 16.

Function
REQ-004 The block SHALL contain an FSM with exactly three states: IDLE, CALC and DONE.
REQ-005 In IDLE, start=1 at an edge SHALL be accepted and SHALL cause the following at that edge:
- capture M = sign-extended a, 9 bits
- set Q = b
- clear the accumulator ACC (9 bits)
- set q_1 = 0 and cnt = 0
- move to CALC
REQ-006 In IDLE with start=0, the state and all registers SHALL hold.
REQ-007 In CALC, each edge SHALL perform one radix-2 Booth step using {Q[0], q_1}:
- 01: ACC = ACC + M
- 10: ACC = ACC - M
- 00 or 11: no add
- then arithmetic-shift {ACC, Q, q_1} right by 1, replicating ACC[8]
- then increment cnt
REQ-008 The add or subtract SHALL be done modulo 2^9 on ACC; the 9-bit width SHALL give the correct result for a = -128.
REQ-009 At the CALC edge where cnt = 7 (the 8th step), the FSM SHALL move to DONE, and prod SHALL be loaded with bits [15:0] of the post-shift {ACC, Q}.
REQ-010 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge unconditionally.
REQ-011 Latency: if start is accepted at edge k, then done=1 and a valid prod SHALL appear in the cycle after edge k+8 (9 cycles from acceptance).
REQ-012 busy SHALL be 1 exactly while in CALC, i.e. the 8 cycles after acceptance, and 0 in IDLE and DONE.
REQ-013 start SHALL be ignored in CALC and DONE; no queuing SHALL occur, and a/b changes during CALC SHALL NOT affect the result.
REQ-014 The earliest back-to-back operation SHALL be start held high in the IDLE cycle that follows DONE, giving a throughput of one result per 10 cycles.
REQ-015 prod SHALL hold its last value from DONE through IDLE and the next CALC, until the next DONE load.
REQ-016 prod SHALL equal the exact signed product for all 65536 operand pairs, including -128*-128 = 16384 (0x4000).
REQ-017 done and busy SHALL be registered outputs, free of combinational paths from start, a or b.

Reset
REQ-018 rst=1 at an edge SHALL force the following, taking priority over every other condition including start=1:
- state = IDLE
- busy = 0, done = 0, prod = 16'h0000
- ACC, Q, M, q_1 and cnt cleared
REQ-019 Reset asserted mid-CALC SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL behave as from power-up.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- a=3, b=5, start pulsed one cycle -> busy high 8 cycles; done in cycle 9 after acceptance with prod=16'h000F.
- a=-128, b=-128 -> prod=16'h4000; a=-1, b=127 -> prod=16'hFF81; a=-128, b=127 -> prod=16'hC080.
- start=1 with a=2, b=2 during CALC of 7*6 -> second request ignored; prod=16'h002A; exactly one done pulse.
- rst=1 at the 4th CALC cycle -> next cycle busy=0, done=0, prod=0; no done pulse follows; a new 4*4 after reset -> prod=16'h0010.
- start held high continuously, operands 1*1 then 2*3 -> done pulses 10 cycles apart with prod 16'h0001 then 16'h0006.
- Randomized exhaustive sweep of all 65536 pairs against a signed reference model -> zero mismatches.
